// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin pick between two requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req_0, req_1  requests
//   last_owner    requester served most recently
//   valid         at least one request is present
//   winner        chosen requester (meaningful only with valid)
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic    req_0,
    input  logic    req_1,
    input  req_id_t last_owner,
    output logic    valid,
    output req_id_t winner
);

    assign valid = req_0 | req_1;

    // On a tie the requester that was not served last wins; otherwise the
    // single active requester wins (req_1 alone selects 1, else 0).
    assign winner = (req_0 & req_1) ? ~last_owner : req_1;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two masters.
// Latency: grant 1 cycle after req is seen in IDLE; read data 1 cycle after grant.
// Backpressure: requesters hold req and operands until their gnt pulse; others wait.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_x/we_x/addr_x/wdata_x      requester x operation (x = 0, 1)
//   gnt_x                          one-cycle pulse: operation is on the memory port
//   rvalid_x/rdata_x               one-cycle read-data strobe and data
//   busy                           arbiter is not idle
//   mem_we/mem_addr/mem_wdata      memory port drive
//   mem_rdata                      registered memory read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_0,
    input  logic         req_1,
    input  logic         we_0,
    input  logic         we_1,
    input  logic [N-1:0] addr_0,
    input  logic [N-1:0] addr_1,
    input  logic [N-1:0] wdata_0,
    input  logic [N-1:0] wdata_1,
    output logic         gnt_0,
    output logic         gnt_1,
    output logic         rvalid_0,
    output logic         rvalid_1,
    output logic [N-1:0] rdata_0,
    output logic [N-1:0] rdata_1,
    output logic         busy,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    arb_state_t           state_q;
    req_id_t              owner_q;
    req_id_t              last_owner_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   rvalid_q;
    logic                 busy_q;
    logic                 mem_we_q;
    logic [N-1:0]         mem_addr_q;
    logic [N-1:0]         mem_wdata_q;

    logic                 pick_valid;
    req_id_t              pick_winner;
    logic                 op_we_d;
    logic [N-1:0]         op_addr_d;
    logic [N-1:0]         op_wdata_d;

    rr_pick2 u_pick (
        .req_0      (req_0),
        .req_1      (req_1),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Operands of whichever requester the picker selected.
    assign op_we_d    = pick_winner ? we_1    : we_0;
    assign op_addr_d  = pick_winner ? addr_1  : addr_0;
    assign op_wdata_d = pick_winner ? wdata_1 : wdata_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;    // requester 0 wins the first tie
            gnt_q        <= '0;
            rvalid_q     <= '0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q              <= ARB_ACCESS;
                        owner_q              <= pick_winner;
                        gnt_q[pick_winner]   <= 1'b1;
                        busy_q               <= 1'b1;
                        mem_we_q             <= op_we_d;
                        mem_addr_q           <= op_addr_d;
                        mem_wdata_q          <= op_wdata_d;
                    end
                end
                ARB_ACCESS: begin
                    gnt_q    <= '0;
                    mem_we_q <= 1'b0;
                    // mem_we_q still holds the latched operation type here.
                    if (mem_we_q) begin
                        last_owner_q <= owner_q;
                        state_q      <= ARB_IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        state_q           <= ARB_RESP;
                        rvalid_q[owner_q] <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    rvalid_q     <= '0;
                    last_owner_q <= owner_q;
                    state_q      <= ARB_IDLE;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    gnt_q    <= '0;
                    rvalid_q <= '0;
                    busy_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_0     = gnt_q[0];
    assign gnt_1     = gnt_q[1];
    assign rvalid_0  = rvalid_q[0];
    assign rvalid_1  = rvalid_q[1];
    assign rdata_0   = mem_rdata;
    assign rdata_1   = mem_rdata;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model with its own memory image.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req   [2];
    logic       we    [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];

    logic       gnt_0, gnt_1, rvalid_0, rvalid_1, busy, mem_we;
    logic [7:0] rdata_0, rdata_1, mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_0     (req[0]),
        .req_1     (req[1]),
        .we_0      (we[0]),
        .we_1      (we[1]),
        .addr_0    (addr[0]),
        .addr_1    (addr[1]),
        .wdata_0   (wdata[0]),
        .wdata_1   (wdata[1]),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .rvalid_0  (rvalid_0),
        .rvalid_1  (rvalid_1),
        .rdata_0   (rdata_0),
        .rdata_1   (rdata_1),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory instance stand-in: synchronous write, registered read.
    logic       mem_init;
    logic [7:0] mem_arr [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i) ^ 8'h5A;
        end else begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // cyc counts rising edges since reset; cycle n is the interval after edge n.
    // The arbiter is free in cycle n when n >= idle_from. A grant seen at edge n
    // occupies cycle n (grant); a read also yields data in cycle n+1.
    int         cyc, idle_from, pend_cyc;
    int         last, pend_id, w;
    logic [7:0] pend_data;
    logic [7:0] model_mem [256];
    logic       exp_g [2];
    logic       exp_rv [2];
    logic       exp_we, exp_busy;
    logic [7:0] exp_addr, exp_wdata, exp_rdata;

    task automatic model_reset();
        cyc = 0; idle_from = 0; pend_cyc = -1; last = 1; pend_id = 0;
        pend_data = '0;
        exp_g[0] = 0; exp_g[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0;
        exp_we = 0; exp_busy = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                exp_g[0] = 0; exp_g[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0; exp_we = 0;
                if (pend_cyc == cyc) begin
                    exp_rv[pend_id] = 1;
                    exp_rdata = pend_data;
                end
                if (cyc - 1 >= idle_from && (req[0] || req[1])) begin
                    if (req[0] && req[1]) w = 1 - last;
                    else                  w = req[1] ? 1 : 0;
                    exp_g[w]  = 1;
                    exp_we    = we[w];
                    exp_addr  = addr[w];
                    exp_wdata = wdata[w];
                    if (we[w]) begin
                        model_mem[addr[w]] = wdata[w];
                        idle_from = cyc + 1;
                    end else begin
                        pend_cyc  = cyc + 1;
                        pend_id   = w;
                        pend_data = model_mem[addr[w]];
                        idle_from = cyc + 2;
                    end
                    last = w;
                end
                exp_busy = (cyc < idle_from);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("gnt_0",     32'(gnt_0),     32'(exp_g[0]));
            chk("gnt_1",     32'(gnt_1),     32'(exp_g[1]));
            chk("rvalid_0",  32'(rvalid_0),  32'(exp_rv[0]));
            chk("rvalid_1",  32'(rvalid_1),  32'(exp_rv[1]));
            chk("mem_we",    32'(mem_we),    32'(exp_we));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            if (exp_rv[0]) chk("rdata_0", 32'(rdata_0), 32'(exp_rdata));
            if (exp_rv[1]) chk("rdata_1", 32'(rdata_1), 32'(exp_rdata));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic gnt_of(input int i);
        return (i == 1) ? gnt_1 : gnt_0;
    endfunction

    task automatic set_op(input int i, input logic r, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
        req[i] = r; we[i] = wr; addr[i] = a; wdata[i] = d;
    endtask

    task automatic new_op(input int i);
        req[i]   = 1'b1;
        we[i]    = 1'($urandom_range(1, 0));
        addr[i]  = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(15, 0))
                                               : 8'($urandom_range(255, 0));
        wdata[i] = 8'($urandom_range(255, 0));
    endtask

    // One falling-edge step of two protocol-abiding random requesters.
    task automatic drive_step(input bit stop);
        for (int i = 0; i < 2; i++) begin
            if (req[i] && gnt_of(i)) begin
                if (!stop && $urandom_range(1, 0) == 1) new_op(i);
                else req[i] = 1'b0;
            end else if (!req[i] && !stop && $urandom_range(2, 0) == 0) begin
                new_op(i);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        rst_n = 1'b0;
        mem_init = 1'b1;
        set_op(0, 1'b1, 1'b0, 8'h03, 8'h00);
        set_op(1, 1'b1, 1'b1, 8'h04, 8'h11);

        // Reset held with both requests high.
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt",    32'({gnt_0, gnt_1}),       32'h0);
            chk("rst_rvalid", 32'({rvalid_0, rvalid_1}), 32'h0);
            chk("rst_we_busy",32'({mem_we, busy}),       32'h0);
            chk("rst_addr",   32'(mem_addr),             32'h0);
        end
        mem_init = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        rst_n = 1'b1;

        // Single write then read by requester 0.
        @(negedge clk);
        set_op(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        chk("wr_gnt_0",  32'(gnt_0),    32'h1);
        chk("wr_we",     32'(mem_we),   32'h1);
        chk("wr_addr",   32'(mem_addr), 32'h10);
        req[0] = 1'b0;
        @(negedge clk);
        chk("wr_idle_busy", 32'(busy), 32'h0);
        set_op(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("rd_gnt_0", 32'(gnt_0), 32'h1);
        chk("rd_we",    32'(mem_we), 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("rd_rvalid_0", 32'(rvalid_0), 32'h1);
        chk("rd_rdata_0",  32'(rdata_0),  32'hA5);
        chk("rd_rvalid_1", 32'(rvalid_1), 32'h0);
        @(negedge clk);

        // Contention on reads right after reset.
        apply_reset();
        set_op(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_op(1, 1'b1, 1'b0, 8'h02, 8'h00);
        @(negedge clk);
        chk("cont_first", 32'({gnt_1, gnt_0}), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        chk("cont_rv0",    32'({rvalid_1, rvalid_0}), 32'h1);
        chk("cont_rdata0", 32'(rdata_0), 32'h5B);
        @(negedge clk);
        chk("cont_idle", 32'({gnt_1, gnt_0}), 32'h0);
        @(negedge clk);
        chk("cont_second", 32'({gnt_1, gnt_0}), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);
        chk("cont_rv1",    32'({rvalid_1, rvalid_0}), 32'h2);
        chk("cont_rdata1", 32'(rdata_1), 32'h58);
        @(negedge clk);

        // Fairness: both hold write requests continuously for 8 grants.
        set_op(0, 1'b1, 1'b1, 8'h30, 8'hC0);
        set_op(1, 1'b1, 1'b1, 8'h31, 8'hC1);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (gnt_0 || gnt_1) begin
                chk("fair_owner", 32'(gnt_1), 32'(k % 2));
                k++;
                if (k == 8) begin req[0] = 1'b0; req[1] = 1'b0; end
            end
        end
        chk("fair_count", 32'(k), 32'd8);
        @(negedge clk);

        // Reset during the response cycle of a read by requester 1.
        set_op(1, 1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        chk("rr_gnt_1", 32'(gnt_1), 32'h1);
        req[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rr_no_rvalid", 32'(rvalid_1), 32'h0);
        chk("rr_busy",      32'(busy),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_idle_busy", 32'(busy), 32'h0);
        set_op(0, 1'b1, 1'b1, 8'h40, 8'h44);
        set_op(1, 1'b1, 1'b1, 8'h41, 8'h45);
        @(negedge clk);
        chk("rr_tie_to_0", 32'({gnt_1, gnt_0}), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_then_1", 32'({gnt_1, gnt_0}), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);

        // Late request: req_1 rises during requester 0's access cycle.
        set_op(0, 1'b1, 1'b1, 8'h50, 8'h77);
        @(negedge clk);
        chk("late_gnt_0", 32'(gnt_0), 32'h1);
        req[0] = 1'b0;
        set_op(1, 1'b1, 1'b0, 8'h50, 8'h00);
        @(negedge clk);
        chk("late_idle_gnt_1", 32'(gnt_1), 32'h0);
        chk("late_idle_busy",  32'(busy),  32'h0);
        @(negedge clk);
        chk("late_gnt_1", 32'(gnt_1), 32'h1);
        req[1] = 1'b0;
        @(negedge clk);
        chk("late_rv1",    32'(rvalid_1), 32'h1);
        chk("late_rdata1", 32'(rdata_1),  32'h77);
        @(negedge clk);

        // Random traffic from both requesters.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive_step(1'b0);
        end
        for (int c = 0; c < 40 && (req[0] || req[1]); c++) begin
            @(negedge clk);
            drive_step(1'b1);
        end
        chk("drain_done", 32'({req[0], req[1]}), 32'h0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
